// File: rtl/uart_pkg.sv
// Constants, FSM state encoding and parity helper shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead circular buffer; rdata always presents the oldest entry while not empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered bytes sent as start, 8 data LSB first, even parity, stop.
//
// state     | meaning
// ST_IDLE   | line high, waiting for a buffered byte
// ST_START  | start bit (0) for one bit period
// ST_DATA   | eight data bits, LSB first, one period each
// ST_PARITY | even parity of the byte
// ST_STOP   | stop bit (1); chains straight into the next START if data is waiting
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int BIT_CLKS = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int IDX_W    = $clog2(DATA_BITS);
  localparam int OCC_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 line_bit;
  logic                 baud_tc;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OCC_W-1:0]     fifo_count;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid),
    .wdata (data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ready   = !fifo_full;
  assign busy    = (state != ST_IDLE) || (fifo_count != '0);
  assign baud_tc = (baud_cnt == '0);

  // A new frame is fetched from idle, or at the very end of a stop bit so frames abut.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_STOP) && baud_tc));

  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_IDLE:   line_bit = 1'b1;
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shreg[0];
      ST_PARITY: line_bit = par_bit;
      ST_STOP:   line_bit = 1'b1;
      default:   line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx <= line_bit;
      if (pop) begin
        shreg    <= fifo_rdata;
        par_bit  <= even_parity(fifo_rdata);
        baud_cnt <= BIT_LAST;
        bit_idx  <= '0;
        state    <= ST_START;
      end else if (state != ST_IDLE) begin
        if (!baud_tc) begin
          baud_cnt <= baud_cnt - 1'b1;
        end else begin
          baud_cnt <= BIT_LAST;
          case (state)
            ST_START: state <= ST_DATA;
            ST_DATA: begin
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == IDX_LAST) begin
                state <= ST_PARITY;
              end
            end
            ST_PARITY: state <= ST_STOP;
            ST_STOP:   state <= ST_IDLE;
            default:   state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: line activity logged each cycle and compared against a frame-level model.
module tb_uart_tx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int BITC   = 10;
  localparam int FRAME  = 11 * BITC;
  localparam int LOG_N  = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic       tx;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;

  logic txlog    [LOG_N];
  logic busylog  [LOG_N];
  logic readylog [LOG_N];

  always #5 clk = ~clk;

  uart_tx #(
    .CLOCK_RATE (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .tx    (tx),
    .busy  (busy)
  );

  // Log index e holds the outputs as seen just after rising edge e.
  initial begin
    forever begin
      @(posedge clk);
      edge_no++;
      #1;
      if (edge_no < LOG_N) begin
        txlog[edge_no]    = tx;
        busylog[edge_no]  = busy;
        readylog[edge_no] = ready;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference frame: index 0 start, 1..8 data LSB first, 9 even parity, 10 stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 1);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic int wave_errs(input int start, input logic [7:0] b);
    logic [10:0] f;
    int n;
    f = frame_of(b);
    n = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (start + i >= LOG_N || start + i < 1) n++;
      else if (txlog[start+i] !== f[i/BITC]) n++;
    end
    return n;
  endfunction

  // Line-level receiver: samples mid-bit, returns {stop, parity, data}.
  function automatic logic [9:0] rx_decode(input int start);
    logic [9:0] r;
    r = '0;
    for (int i = 1; i <= 10; i++) begin
      if (start + 5 + BITC * i < LOG_N) r[i-1] = txlog[start + 5 + BITC * i];
      else r[i-1] = 1'bx;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b0;
    repeat (3) tick();
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_55();
    int k;
    int n;
    logic [10:0] f;
    f = frame_of(8'h55);
    data = 8'h55;
    valid = 1'b1;
    tick();
    k = edge_no;
    valid = 1'b0;
    repeat (120) tick();
    tests++;
    if (txlog[k+1] !== 1'b1) begin fails++; $display("FAIL latency_k1: tx=%b want 1", txlog[k+1]); end
    tests++;
    if (txlog[k+2] !== 1'b0) begin fails++; $display("FAIL latency_k2: tx=%b want 0", txlog[k+2]); end
    for (int b = 0; b < 11; b++) begin
      n = 0;
      for (int c = 0; c < BITC; c++) if (txlog[k+2+BITC*b+c] !== f[b]) n++;
      tests++;
      if (n != 0) begin
        fails++;
        $display("FAIL frame55_bit%0d: %0d cycles differ from required level %b", b, n, f[b]);
      end
    end
    tests++;
    if (busylog[k+1] !== 1'b1 || busylog[k+110] !== 1'b1) begin
      fails++;
      $display("FAIL busy_during: got %b/%b want 1/1", busylog[k+1], busylog[k+110]);
    end
    tests++;
    if (busylog[k+112] !== 1'b0 || txlog[k+112] !== 1'b1) begin
      fails++;
      $display("FAIL frame55_end: busy=%b tx=%b want busy=0 tx=1", busylog[k+112], txlog[k+112]);
    end
  endtask

  task automatic test_parity_01();
    int k;
    int s;
    logic [9:0] r;
    data = 8'h01;
    valid = 1'b1;
    tick();
    k = edge_no;
    valid = 1'b0;
    repeat (125) tick();
    s = k;
    while (s < k + 20 && txlog[s] !== 1'b0) s++;
    r = rx_decode(s);
    tests++;
    if (r[7:0] !== 8'h01) begin fails++; $display("FAIL rx01_data: got %h want 01", r[7:0]); end
    tests++;
    if (r[8] !== 1'b1) begin fails++; $display("FAIL rx01_parity_bit: got %b want 1", r[8]); end
    tests++;
    if ((r[8] ^ (($countones(r[7:0]) % 2) == 1)) !== 1'b0) begin
      fails++;
      $display("FAIL rx01_parity_err: parity bit %b inconsistent with data %h", r[8], r[7:0]);
    end
    tests++;
    if (r[9] !== 1'b1) begin fails++; $display("FAIL rx01_stop: got %b want 1", r[9]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [7];
    logic [9:0] r;
    int i;
    int g;
    int k0;
    int n;
    logic rd;
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A, 8'hC3};
    i = 0;
    g = 0;
    k0 = 0;
    data = bytes[0];
    valid = 1'b1;
    while (i < 7 && g < 2000) begin
      rd = ready;
      tick();
      if (rd) begin
        if (i == 0) k0 = edge_no;
        i++;
        if (i < 7) data = bytes[i];
      end
      g++;
    end
    valid = 1'b0;
    tests++;
    if (i != 7) begin fails++; $display("FAIL b2b_accept: accepted %0d want 7", i); end
    tests++;
    if ({readylog[k0], readylog[k0+1], readylog[k0+2], readylog[k0+3]} !== 4'b1111) begin
      fails++;
      $display("FAIL b2b_ready_early: got %b want 1111",
               {readylog[k0], readylog[k0+1], readylog[k0+2], readylog[k0+3]});
    end
    tests++;
    if (readylog[k0+4] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready_full: got %b want 0", readylog[k0+4]);
    end
    g = 0;
    while (edge_no < k0 + 7 * FRAME + 10 && g < 2000) begin tick(); g++; end
    for (int f = 0; f < 7; f++) begin
      n = wave_errs(k0 + 2 + FRAME * f, bytes[f]);
      tests++;
      if (n != 0) begin
        fails++;
        $display("FAIL b2b_frame%0d: %0d cycles differ from contiguous frame of %h", f, n, bytes[f]);
      end
      if (f < 5) begin
        r = rx_decode(k0 + 2 + FRAME * f);
        tests++;
        if (r[8] !== 1'b0) begin fails++; $display("FAIL b2b_parity%0d: got %b want 0", f, r[8]); end
      end
    end
    tests++;
    if (busylog[k0 + 2 + 7 * FRAME + 2] !== 1'b0 || txlog[k0 + 2 + 7 * FRAME + 2] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_end: busy=%b tx=%b want 0/1",
               busylog[k0 + 2 + 7 * FRAME + 2], txlog[k0 + 2 + 7 * FRAME + 2]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k0;
    int t0;
    int nt;
    int nb;
    int nr;
    data = 8'h0F;
    valid = 1'b1;
    tick();
    k0 = edge_no;
    data = 8'h12;
    tick();
    data = 8'h34;
    tick();
    valid = 1'b0;
    while (edge_no < k0 + 44) tick();
    rst = 1'b1;
    tick();
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL midrst_tx: got %b want 1", tx); end
    rst = 1'b0;
    t0 = edge_no;
    repeat (300) tick();
    nt = 0;
    nb = 0;
    nr = 0;
    for (int e = t0 + 1; e <= t0 + 300; e++) begin
      if (txlog[e] !== 1'b1) nt++;
      if (busylog[e] !== 1'b0) nb++;
      if (readylog[e] !== 1'b1) nr++;
    end
    tests++;
    if (nt != 0) begin fails++; $display("FAIL midrst_no_frames: %0d cycles tx!=1 want 0", nt); end
    tests++;
    if (nb != 0) begin fails++; $display("FAIL midrst_busy: %0d cycles busy!=0 want 0", nb); end
    tests++;
    if (nr != 0) begin fails++; $display("FAIL midrst_ready: %0d cycles ready!=1 want 0", nr); end
    // Abort while the start bit is on the line.
    data = 8'hF0;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (5) tick();
    tests++;
    if (tx !== 1'b0) begin fails++; $display("FAIL startbit_pre: got %b want 0", tx); end
    rst = 1'b1;
    tick();
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL startrst_tx: got %b want 1", tx); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle();
    int t0;
    int nt;
    int nb;
    valid = 1'b0;
    t0 = edge_no;
    repeat (1000) tick();
    nt = 0;
    nb = 0;
    for (int e = t0 + 1; e <= t0 + 1000; e++) begin
      if (txlog[e] !== 1'b1) nt++;
      if (busylog[e] !== 1'b0) nb++;
    end
    tests++;
    if (nt != 0) begin fails++; $display("FAIL idle_tx: %0d cycles tx!=1 want 0", nt); end
    tests++;
    if (nb != 0) begin fails++; $display("FAIL idle_busy: %0d cycles busy!=0 want 0", nb); end
  endtask

  task automatic test_random();
    logic [7:0] sent [$];
    logic [9:0] r;
    int t0;
    int g;
    int pos;
    int n;
    t0 = edge_no;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 150)) tick();
      data = 8'($urandom);
      valid = 1'b1;
      g = 0;
      while (ready !== 1'b1 && g < 500) begin tick(); g++; end
      if (g >= 500) begin
        tests++;
        fails++;
        $display("FAIL rand_ready_timeout: ready stuck at %b want 1", ready);
      end else begin
        tick();
        sent.push_back(data);
      end
      valid = 1'b0;
    end
    g = 0;
    while (busy !== 1'b0 && g < 2000) begin tick(); g++; end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rand_drain: busy=%b want 0", busy); end
    repeat (3) tick();
    pos = t0 + 1;
    foreach (sent[j]) begin
      while (pos < edge_no && !(txlog[pos] === 1'b0 && txlog[pos-1] === 1'b1)) pos++;
      tests++;
      if (pos >= edge_no) begin
        fails++;
        $display("FAIL rand_missing%0d: no start bit found, want byte %h", j, sent[j]);
      end else begin
        r = rx_decode(pos);
        n = wave_errs(pos, sent[j]);
        if (r[7:0] !== sent[j] || n != 0) begin
          fails++;
          $display("FAIL rand_frame%0d: got %h (%0d bad cycles) want %h", j, r[7:0], n, sent[j]);
        end
        pos += FRAME;
      end
    end
    n = 0;
    for (int e = pos; e < edge_no; e++) if (txlog[e] !== 1'b1) n++;
    tests++;
    if (n != 0) begin fails++; $display("FAIL rand_extra: %0d low cycles after last frame want 0", n); end
  endtask

  initial begin
    test_reset();
    test_single_55();
    test_parity_01();
    test_back_to_back();
    test_reset_mid_frame();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
